reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb_pkg.sv | 16 +
 rtl/reg_file_sb_if.sv | 36 +++
 rtl/reg_file_sb_reg_nb.sv | 30 +++
 rtl/reg_file_sb.sv | 109 ++++++++++
 tb/tb_reg_file_sb.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: shared constants for the register file with scoreboard.
// Holds the default parameter values and the controller state encoding
// used by reg_file_sb, its sub-module and its bus interface.
package reg_file_sb_pkg;

   localparam int DEF_WIDTH   = 16;
   localparam int DEF_ADDR_W  = 3;
   localparam int DEF_NRD     = 2;
   localparam int DEF_ZERO_R0 = 0;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: bus bundle between a register file client and reg_file_sb.
//   wr/waddr/wdata      write-back port
//   raddr/rdata/rbusy   NRD packed read ports with per-port busy flag
//   rsv/rsv_addr        reservation of a destination register
//   clr/clr_busy        clear request and clear-in-progress status
// master = client side, slave = register file side.
interface reg_file_sb_if
   import reg_file_sb_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NRD    = DEF_NRD
) ();

   logic                  wr;
   logic [ADDR_W-1:0]     waddr;
   logic [WIDTH-1:0]      wdata;
   logic [NRD*ADDR_W-1:0] raddr;
   logic [NRD*WIDTH-1:0]  rdata;
   logic [NRD-1:0]        rbusy;
   logic                  rsv;
   logic [ADDR_W-1:0]     rsv_addr;
   logic                  clr;
   logic                  clr_busy;

   modport master (
      output wr, waddr, wdata, raddr, rsv, rsv_addr, clr,
      input  rdata, rbusy, clr_busy
   );

   modport slave (
      input  wr, waddr, wdata, raddr, rsv, rsv_addr, clr,
      output rdata, rbusy, clr_busy
   );

endinterface

// File: rtl/reg_file_sb_reg_nb.sv
// reg_nb: WIDTH-bit register with load enable and asynchronous active-low
// reset to zero. One instance holds one entry of the register file.
//   clk   clock
//   rstn  asynchronous active-low reset
//   en_i  load enable
//   d_i   data to load
//   q_o   stored value
module reg_nb #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         data_q <= '0;
      end else if (en_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2**ADDR_W x WIDTH register file with NRD combinational read
// ports, write-to-read bypass, a per-register busy scoreboard and a
// sequential clear engine (one entry per cycle).
//   clk   clock, all state updates on the rising edge
//   rstn  asynchronous active-low reset
//   bus   reg_file_sb_if slave modport (write, read, reserve, clear)
module reg_file_sb
   import reg_file_sb_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int NRD     = DEF_NRD,
   parameter int ZERO_R0 = DEF_ZERO_R0
) (
   input logic           clk,
   input logic           rstn,
   reg_file_sb_if.slave  bus
);

   localparam int DEPTH = 2**ADDR_W;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [WIDTH-1:0]  regs [DEPTH];
   logic              idle;
   logic              clearing;
   logic              wr_ok;
   logic              rsv_ok;

   // Writes and reservations to r0 are dropped when r0 is hard-wired zero.
   assign wr_ok  = idle && bus.wr
                   && !((ZERO_R0 != 0) && (bus.waddr == '0));
   assign rsv_ok = idle && bus.rsv
                   && !((ZERO_R0 != 0) && (bus.rsv_addr == '0));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (bus.clr) state_d = ST_CLEAR;
         ST_CLEAR: if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      idle         = (state_q == ST_IDLE);
      clearing     = (state_q == ST_CLEAR);
      bus.clr_busy = clearing;
   end

   // The counter only moves in CLEAR; the final increment wraps it to 0.
   assign cnt_d = clearing ? cnt_q + ADDR_W'(1) : '0;

   always_comb begin
      busy_d = busy_q;
      if (idle) begin
         if (wr_ok)  busy_d[bus.waddr]    = 1'b0;
         // Applied after the clear so a same-address reserve wins.
         if (rsv_ok) busy_d[bus.rsv_addr] = 1'b1;
      end else begin
         busy_d[cnt_q] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q  <= '0;
         busy_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   for (genvar j = 0; j < DEPTH; j++) begin : g_store
      logic en;
      assign en = (wr_ok && (bus.waddr == ADDR_W'(j)))
                  || (clearing && (cnt_q == ADDR_W'(j)));
      reg_nb #(.WIDTH(WIDTH)) u_reg (
         .clk  (clk),
         .rstn (rstn),
         .en_i (en),
         .d_i  (clearing ? '0 : bus.wdata),
         .q_o  (regs[j])
      );
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              byp;
      assign ra  = bus.raddr[i*ADDR_W +: ADDR_W];
      assign byp = wr_ok && (bus.waddr == ra);
      assign bus.rdata[i*WIDTH +: WIDTH] =
         byp                               ? bus.wdata :
         ((ZERO_R0 != 0) && (ra == '0))    ? '0        : regs[ra];
      // A write in flight to this address resolves the pending producer.
      assign bus.rbusy[i] = busy_q[ra] && !byp;
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scoreboard bench for reg_file_sb. A default build is
// compared every cycle against a behavioural model; a second build
// (ZERO_R0=1, NRD=3, WIDTH=32) gets directed vectors.
module tb_reg_file_sb;

   logic clk;
   logic rstn;
   int   n_vec;
   int   n_err;
   logic obs_cb;

   reg_file_sb_if #(.WIDTH(16), .ADDR_W(3), .NRD(2)) bus0 ();
   reg_file_sb_if #(.WIDTH(32), .ADDR_W(3), .NRD(3)) busz ();

   reg_file_sb #(.WIDTH(16), .ADDR_W(3), .NRD(2), .ZERO_R0(0)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus0)
   );

   reg_file_sb #(.WIDTH(32), .ADDR_W(3), .NRD(3), .ZERO_R0(1)) dut_z (
      .clk  (clk),
      .rstn (rstn),
      .bus  (busz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  rbusy;
      logic        clr_busy;
   } exp_t;

   typedef struct {
      logic [95:0] rdata;
      logic [2:0]  rbusy;
   } expz_t;

   exp_t  sb_q[$];
   expz_t sbz_q[$];

   logic [15:0] m_reg [8];
   logic [7:0]  m_busy;
   logic        m_clear;
   logic [2:0]  m_cnt;

   task automatic check_val(input string tag, input logic [95:0] obs,
                            input logic [95:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 8; k++) m_reg[k] = '0;
      m_busy  = '0;
      m_clear = 1'b0;
      m_cnt   = '0;
   endtask

   // One clock cycle on the default build: drive, predict, compare, advance.
   task automatic cyc(input logic wr, input logic [2:0] wa,
                      input logic [15:0] wd, input logic rsv,
                      input logic [2:0] rsa, input logic clr,
                      input logic [2:0] r0, input logic [2:0] r1);
      exp_t       e;
      logic [2:0] ra [2];
      bus0.wr       = wr;
      bus0.waddr    = wa;
      bus0.wdata    = wd;
      bus0.rsv      = rsv;
      bus0.rsv_addr = rsa;
      bus0.clr      = clr;
      bus0.raddr    = {r1, r0};
      ra[0] = r0;
      ra[1] = r1;
      for (int i = 0; i < 2; i++) begin
         if (!m_clear && wr && (wa == ra[i])) begin
            e.rdata[i*16 +: 16] = wd;
            e.rbusy[i]          = 1'b0;
         end else begin
            e.rdata[i*16 +: 16] = m_reg[ra[i]];
            e.rbusy[i]          = m_busy[ra[i]];
         end
      end
      e.clr_busy = m_clear;
      sb_q.push_back(e);
      @(negedge clk);
      e = sb_q.pop_front();
      obs_cb = bus0.clr_busy;
      check_val("rdata",    96'(bus0.rdata),    96'(e.rdata));
      check_val("rbusy",    96'(bus0.rbusy),    96'(e.rbusy));
      check_val("clr_busy", 96'(bus0.clr_busy), 96'(e.clr_busy));
      @(posedge clk);
      if (!m_clear) begin
         if (wr) begin
            m_reg[wa]  = wd;
            m_busy[wa] = 1'b0;
         end
         if (rsv) m_busy[rsa] = 1'b1;
         if (clr) begin
            m_clear = 1'b1;
            m_cnt   = '0;
         end
      end else begin
         m_reg[m_cnt]  = '0;
         m_busy[m_cnt] = 1'b0;
         if (m_cnt == 3'd7) m_clear = 1'b0;
         m_cnt = m_cnt + 3'd1;
      end
      #1;
   endtask

   // One clock cycle on the ZERO_R0 build with caller-supplied expectations.
   task automatic zcyc(input string tag, input logic wr, input logic [2:0] wa,
                       input logic [31:0] wd, input logic rsv,
                       input logic [2:0] rsa, input logic [8:0] raddr,
                       input logic [95:0] exp_rd, input logic [2:0] exp_rb);
      expz_t e;
      busz.wr       = wr;
      busz.waddr    = wa;
      busz.wdata    = wd;
      busz.rsv      = rsv;
      busz.rsv_addr = rsa;
      busz.clr      = 1'b0;
      busz.raddr    = raddr;
      e.rdata = exp_rd;
      e.rbusy = exp_rb;
      sbz_q.push_back(e);
      @(negedge clk);
      e = sbz_q.pop_front();
      check_val({tag, "_rdata"}, busz.rdata,        e.rdata);
      check_val({tag, "_rbusy"}, 96'(busz.rbusy),   96'(e.rbusy));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_hi;
      n_vec = 0;
      n_err = 0;
      obs_cb = 1'b0;
      rstn = 1'b0;
      bus0.wr = 1'b0; bus0.waddr = '0; bus0.wdata = '0; bus0.rsv = 1'b0;
      bus0.rsv_addr = '0; bus0.clr = 1'b0; bus0.raddr = '0;
      busz.wr = 1'b0; busz.waddr = '0; busz.wdata = '0; busz.rsv = 1'b0;
      busz.rsv_addr = '0; busz.clr = 1'b0; busz.raddr = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_rdata",    96'(bus0.rdata),    96'h0);
      check_val("rst_rbusy",    96'(bus0.rbusy),    96'h0);
      check_val("rst_clr_busy", 96'(bus0.clr_busy), 96'h0);
      check_val("rst_z_rdata",  busz.rdata,         96'h0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // write then read, and same-cycle bypass
      cyc(1, 3'd5, 16'hBEEF, 0, 3'd0, 0, 3'd0, 3'd0);
      cyc(1, 3'd3, 16'h1234, 0, 3'd0, 0, 3'd5, 3'd3);

      // reservation, busy flag, resolve by write-back
      cyc(0, 3'd0, 16'h0000, 1, 3'd2, 0, 3'd0, 3'd0);
      cyc(0, 3'd0, 16'h0000, 0, 3'd0, 0, 3'd2, 3'd5);
      cyc(1, 3'd2, 16'h0042, 0, 3'd0, 0, 3'd2, 3'd2);
      cyc(0, 3'd0, 16'h0000, 0, 3'd0, 0, 3'd2, 3'd3);

      // reserve and write the same register together: reserve wins
      cyc(1, 3'd4, 16'h5555, 1, 3'd4, 0, 3'd4, 3'd4);
      cyc(0, 3'd0, 16'h0000, 0, 3'd0, 0, 3'd4, 3'd4);
      cyc(0, 3'd0, 16'h0000, 1, 3'd4, 0, 3'd4, 3'd2);

      // fill everything, reserve a couple
      for (int a = 0; a < 8; a++)
         cyc(1, 3'(a), 16'($urandom), 0, 3'd0, 0, 3'(a), 3'(a + 1));
      cyc(0, 3'd0, 16'h0000, 1, 3'd1, 0, 3'd1, 3'd6);
      cyc(0, 3'd0, 16'h0000, 1, 3'd6, 0, 3'd1, 3'd6);

      // clear with a coincident write/reserve, then writes during CLEAR
      n_hi = 0;
      cyc(1, 3'd7, 16'hABCD, 1, 3'd0, 1, 3'd7, 3'd0);
      for (int k = 0; k < 8; k++) begin
         cyc(1, 3'(k), 16'($urandom), 1, 3'(k + 3), (k == 2) ? 1'b1 : 1'b0,
             3'(k), 3'(k + 5));
         if (obs_cb) n_hi++;
      end
      for (int a = 0; a < 8; a += 2) begin
         cyc(0, 3'd0, 16'h0000, 0, 3'd0, 0, 3'(a), 3'(a + 1));
         if (obs_cb) n_hi++;
      end
      check_val("clr_len", 96'(n_hi), 96'd8);

      // reset in the third cycle of CLEAR
      cyc(1, 3'd5, 16'h1111, 0, 3'd0, 0, 3'd0, 3'd0);
      cyc(1, 3'd7, 16'h2222, 1, 3'd5, 0, 3'd0, 3'd0);
      cyc(0, 3'd0, 16'h0000, 0, 3'd0, 1, 3'd5, 3'd7);
      cyc(0, 3'd0, 16'h0000, 0, 3'd0, 0, 3'd5, 3'd7);
      cyc(0, 3'd0, 16'h0000, 0, 3'd0, 0, 3'd5, 3'd7);
      bus0.raddr = {3'd7, 3'd5};
      #2;
      rstn = 1'b0;
      #1;
      check_val("abort_clr_busy", 96'(bus0.clr_busy), 96'h0);
      check_val("abort_rdata",    96'(bus0.rdata),    96'h0);
      check_val("abort_rbusy",    96'(bus0.rbusy),    96'h0);
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      cyc(0, 3'd0, 16'h0000, 0, 3'd0, 0, 3'd5, 3'd7);

      // random traffic against the model
      for (int n = 0; n < 300; n++)
         cyc(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
             1'($urandom_range(0, 1)), 3'($urandom),
             ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
             3'($urandom), 3'($urandom));
      for (int n = 0; n < 9; n++)
         cyc(0, 3'd0, 16'h0000, 0, 3'd0, 0, 3'(n), 3'(n + 4));

      // ZERO_R0=1, NRD=3, WIDTH=32 build
      bus0.wr = 1'b0; bus0.rsv = 1'b0; bus0.clr = 1'b0;
      zcyc("z_r0_wr", 1, 3'd0, 32'h0000FFFF, 1, 3'd0, 9'd0, 96'h0, 3'b000);
      zcyc("z_r0_rd", 0, 3'd0, 32'h0, 0, 3'd0, 9'd0, 96'h0, 3'b000);
      zcyc("z_wr5", 1, 3'd5, 32'h0000BEEF, 0, 3'd0, 9'd0, 96'h0, 3'b000);
      zcyc("z_byp", 1, 3'd3, 32'h00001234, 0, 3'd0, {3'd0, 3'd3, 3'd5},
           {32'h0, 32'h00001234, 32'h0000BEEF}, 3'b000);
      zcyc("z_rsv6", 0, 3'd0, 32'h0, 1, 3'd6, 9'd0, 96'h0, 3'b000);
      zcyc("z_busy6", 0, 3'd0, 32'h0, 0, 3'd0, {3'd6, 3'd3, 3'd0},
           {32'h0, 32'h00001234, 32'h0}, 3'b100);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
